// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Width of a beat counter that must hold 0..burst_max.
  function automatic int cnt_width(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake plus FIFO write-port bundle for fifo_wr_arbiter.
// master: arbiter view; slave: producers/FIFO view.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int PAR_WRITE = 2,
  parameter int NUM_REQ   = 4
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_last;
  logic [NUM_REQ*SIZE*PAR_WRITE-1:0] req_data;
  logic [NUM_REQ-1:0]                req_ready;
  logic                              fifo_full;
  logic                              fifo_wen;
  logic [SIZE*PAR_WRITE-1:0]         fifo_din;
  logic [ID_W-1:0]                   gnt_id;
  logic                              busy;

  modport master (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wen, fifo_din, gnt_id, busy
  );

  modport slave (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wen, fifo_din, gnt_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index strictly after last_gnt_i.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    last_gnt_i,
  output logic [ID_W-1:0]    pick_o,
  output logic               any_valid_o
);

  // Scan from farthest to nearest so the nearest valid index is written last.
  always_comb begin
    int idx;
    idx         = 0;
    pick_o      = '0;
    any_valid_o = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_gnt_i) + k) % NUM_REQ;
      if (valid_i[idx]) begin
        pick_o      = ID_W'(idx);
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-requester accepted-beat counters: define FIFO_WR_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no grant; arbitrate among valid requesters this cycle
// GRANT | gnt_q owns the FIFO write port until last / cap / producer idle
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int PAR_WRITE = 2,
  parameter int NUM_REQ   = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  fifo_wr_arbiter_if.master            bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic [id_width(NUM_REQ)-1:0] stat_sel,
  output logic [STAT_W-1:0]            stat_cnt
`endif
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = cnt_width(BURST_MAX);
  localparam int DW    = SIZE * PAR_WRITE;

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [ID_W-1:0]    pick;
  logic               any_valid;
  logic [NUM_REQ-1:0] ready;
  logic               wen;
  logic [DW-1:0]      din;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .valid_i     (bus.req_valid),
    .last_gnt_i  (last_q),
    .pick_o      (pick),
    .any_valid_o (any_valid)
  );

  // Next-state, grant bookkeeping and write-port muxing; rst masks the
  // handshake so an abandoned burst never writes in the reset cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    beat_d  = beat_q;
    ready   = '0;
    wen     = 1'b0;
    din     = '0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          gnt_d   = pick;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        ready[gnt_q] = ~bus.fifo_full & ~rst;
        wen          = bus.req_valid[gnt_q] & ~bus.fifo_full & ~rst;
        din          = bus.req_data[int'(gnt_q)*DW +: DW];
        if (wen) begin
          beat_d = beat_q + 1'b1;
          if (bus.req_last[gnt_q] || ((beat_q + 1'b1) == CNT_W'(BURST_MAX))) begin
            state_d = IDLE;
            last_d  = gnt_q;
          end
        end else if (!bus.req_valid[gnt_q] && !bus.fifo_full) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers; last_q resets to NUM_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.fifo_wen  = wen;
  assign bus.fifo_din  = din;
  assign bus.gnt_id    = gnt_q;
  assign bus.busy      = (state_q == GRANT);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];

  // Saturating count of accepted beats per requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (wen && (stat_q[gnt_q] != {STAT_W{1'b1}})) begin
      stat_q[gnt_q] <= stat_q[gnt_q] + 1'b1;
    end
  end

  assign stat_cnt = stat_q[stat_sel];
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a write-order scoreboard.
module tb_fifo_wr_arbiter;

  localparam int SIZE      = 16;
  localparam int PAR_WRITE = 2;
  localparam int NUM_REQ   = 4;
  localparam int BURST_MAX = 4;
  localparam int DW        = SIZE * PAR_WRITE;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  beat_t         pq   [NUM_REQ][$];
  logic [DW-1:0] pend [NUM_REQ][$];
  exp_t          sb   [$];
  int            seq_no [NUM_REQ];
  int            vectors = 0;
  int            errs    = 0;

  logic               o_wen, o_busy;
  logic [1:0]         o_gnt;
  logic [NUM_REQ-1:0] o_ready;
  logic [DW-1:0]      o_din;

  fifo_wr_arbiter_if #(.SIZE(SIZE), .PAR_WRITE(PAR_WRITE), .NUM_REQ(NUM_REQ)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
  logic [1:0]  stat_sel = '0;
  logic [15:0] stat_cnt;
`endif

  fifo_wr_arbiter #(
    .SIZE(SIZE), .PAR_WRITE(PAR_WRITE), .NUM_REQ(NUM_REQ), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // lastmode: 0 none, 1 final beat only, 2 every beat
  task automatic load(input int id, input int n, input int lastmode);
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = {8'(id + 1), 8'(seq_no[id]), 16'h5A3C};
      pq[id].push_back('{data: d, last: (lastmode == 2) || (lastmode == 1 && k == n - 1)});
      pend[id].push_back(d);
      seq_no[id]++;
    end
  endtask

  task automatic expect_wr(input int id, input int n);
    for (int k = 0; k < n; k++) sb.push_back('{id: 2'(id), data: pend[id].pop_front()});
  endtask

  // One clock: drive producer heads, check any write against the scoreboard,
  // then retire accepted beats after the edge.
  task automatic cyc();
    logic [NUM_REQ-1:0]    v, l, acc;
    logic [NUM_REQ*DW-1:0] d;
    exp_t                  e;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pq[i].size() > 0) begin
        v[i] = 1'b1;
        l[i] = pq[i][0].last;
        d[i*DW +: DW] = pq[i][0].data;
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    #2;
    o_wen   = bus.fifo_wen;
    o_busy  = bus.busy;
    o_gnt   = bus.gnt_id;
    o_ready = bus.req_ready;
    o_din   = bus.fifo_din;
    if (o_wen === 1'b1) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_data", 64'(o_din), 64'(e.data));
        chk("wr_id", 64'(o_gnt), 64'(e.id));
      end
    end
    acc = o_ready & v;
    @(posedge clk);
    for (int i = 0; i < NUM_REQ; i++) if (acc[i]) void'(pq[i].pop_front());
    @(negedge clk);
  endtask

  task automatic drain(input int max);
    int  n;
    logic pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < max) begin
      cyc();
      n++;
      pending = o_busy;
      for (int i = 0; i < NUM_REQ; i++) if (pq[i].size() > 0) pending = 1'b1;
    end
    chk("drain_bound", 64'(pending), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < NUM_REQ; i++) seq_no[i] = 0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    @(negedge clk);

    // reset values
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_wen", 64'(o_wen), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_din", 64'(o_din), 64'd0);
    chk("rst_gnt", 64'(o_gnt), 64'd0);
    rst = 1'b0;

    // reset priority: 0,1,2,3,0 with one IDLE between grants
    load(0, 2, 2);
    load(1, 1, 2);
    load(2, 1, 2);
    load(3, 1, 2);
    expect_wr(0, 1); expect_wr(1, 1); expect_wr(2, 1); expect_wr(3, 1); expect_wr(0, 1);
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk("t1_wen", 64'(o_wen), 64'(c % 2));
      chk("t1_busy", 64'(o_busy), 64'(c % 2));
      if (c % 2 == 1) chk("t1_gnt", 64'(o_gnt), 64'(order[c/2]));
    end
    drain(10);

    // burst cap: 2 streams 10 beats, 1 joins
    load(2, 10, 0);
    cyc();
    chk("t2_idle0", 64'(o_busy), 64'd0);
    load(1, 1, 2);
    expect_wr(2, 4); expect_wr(1, 1); expect_wr(2, 6);
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("t2_wen_a", 64'(o_wen), 64'd1);
      chk("t2_gnt_a", 64'(o_gnt), 64'd2);
    end
    cyc();
    chk("t2_cap_idle", 64'(o_busy), 64'd0);
    cyc();
    chk("t2_gnt_1", 64'(o_gnt), 64'd1);
    chk("t2_wen_1", 64'(o_wen), 64'd1);
    cyc();
    chk("t2_idle2", 64'(o_busy), 64'd0);
    cyc();
    chk("t2_gnt_2again", 64'(o_gnt), 64'd2);
    chk("t2_wen_2again", 64'(o_wen), 64'd1);
    drain(30);

    // back-pressure mid-burst
    load(3, 5, 1);
    expect_wr(3, 5);
    cyc();
    cyc();
    chk("t3_wen0", 64'(o_wen), 64'd1);
    cyc();
    chk("t3_wen1", 64'(o_wen), 64'd1);
    bus.fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("t3_full_wen", 64'(o_wen), 64'd0);
      chk("t3_full_ready", 64'(o_ready), 64'd0);
      chk("t3_full_gnt", 64'(o_gnt), 64'd3);
      chk("t3_full_busy", 64'(o_busy), 64'd1);
    end
    bus.fifo_full = 1'b0;
    cyc();
    chk("t3_resume2", 64'(o_wen), 64'd1);
    cyc();
    chk("t3_resume3", 64'(o_wen), 64'd1);
    cyc();
    chk("t3_cap_idle", 64'(o_busy), 64'd0);
    cyc();
    chk("t3_last_wen", 64'(o_wen), 64'd1);
    chk("t3_last_gnt", 64'(o_gnt), 64'd3);
    drain(10);

    // producer drop after 2 beats
    load(0, 2, 0);
    expect_wr(0, 2);
    cyc();
    cyc();
    chk("t4_wen0", 64'(o_wen), 64'd1);
    chk("t4_gnt0", 64'(o_gnt), 64'd0);
    cyc();
    chk("t4_wen1", 64'(o_wen), 64'd1);
    cyc();
    chk("t4_drop_busy", 64'(o_busy), 64'd1);
    chk("t4_drop_wen", 64'(o_wen), 64'd0);
    cyc();
    chk("t4_released", 64'(o_busy), 64'd0);
    load(0, 1, 2);
    load(1, 1, 2);
    expect_wr(1, 1); expect_wr(0, 1);
    drain(10);

    // reset mid-burst
    load(2, 3, 0);
    expect_wr(2, 1);
    cyc();
    cyc();
    chk("t5_wen0", 64'(o_wen), 64'd1);
    rst = 1'b1;
    cyc();
    chk("t5_rst_wen", 64'(o_wen), 64'd0);
    chk("t5_rst_ready", 64'(o_ready), 64'd0);
    rst = 1'b0;
    load(0, 1, 2);
    load(1, 1, 2);
    expect_wr(0, 1); expect_wr(1, 1); expect_wr(2, 2);
    cyc();
    chk("t5_post_busy", 64'(o_busy), 64'd0);
    chk("t5_post_wen", 64'(o_wen), 64'd0);
    chk("t5_post_din", 64'(o_din), 64'd0);
    cyc();
    chk("t5_first_gnt", 64'(o_gnt), 64'd0);
    chk("t5_first_wen", 64'(o_wen), 64'd1);
    drain(20);

`ifdef FIFO_WR_ARB_STATS_EN
    load(3, 5, 1);
    expect_wr(3, 5);
    drain(20);
    stat_sel = 2'd3;
    #1;
    chk("stat_3", 64'(stat_cnt), 64'd5);
    stat_sel = 2'd2;
    #1;
    chk("stat_2", 64'(stat_cnt), 64'd2);
    stat_sel = 2'd0;
    #1;
    chk("stat_0", 64'(stat_cnt), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
